alu_pipe: RTL and testbench

Parametrised, pipelined successor to the 16-bit combinational datapath ALU. It accepts one operation per cycle over a valid/ready handshake and can optionally shift operand B. It returns the result with Z/N/V flags two cycles later and keeps a sticky status register for the controller's branch logic. It sits between the register-file read ports and the writeback mux of the datapath.

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu_core.sv | 36 +++
 rtl/alu_pipe.sv | 160 ++++++++++++++++
 tb/tb_alu_pipe.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared encodings for the pipelined ALU (alu_core, alu_pipe)
package alu_pkg;

   typedef enum logic [1:0] {
      ALU_ADD = 2'b00,
      ALU_SUB = 2'b01,
      ALU_AND = 2'b10,
      ALU_MVN = 2'b11
   } alu_op_e;

   typedef enum logic [1:0] {
      SH_NONE = 2'b00,
      SH_LSL1 = 2'b01,
      SH_LSR1 = 2'b10,
      SH_ASR1 = 2'b11
   } shift_e;

   localparam int ST_Z = 0;
   localparam int ST_N = 1;
   localparam int ST_V = 2;

endpackage

// File: rtl/alu_core.sv
// rtl/alu_core.sv - combinational ALU producing result and Z/N/V flags
module alu_core
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [1:0]       op,
   output logic [WIDTH-1:0] result,
   output logic             z,
   output logic             n,
   output logic             v
);

   always_comb begin
      result = '0;
      v      = 1'b0;
      case (alu_op_e'(op))
         ALU_ADD: begin
            result = a + b;
            v      = (a[WIDTH-1] == b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_SUB: begin
            result = a - b;
            v      = (a[WIDTH-1] != b[WIDTH-1]) && (result[WIDTH-1] != a[WIDTH-1]);
         end
         ALU_AND: result = a & b;
         ALU_MVN: result = ~b;
         default: result = '0;
      endcase
      z = (result == '0);
      n = result[WIDTH-1];
   end

endmodule

// File: rtl/alu_pipe.sv
// rtl/alu_pipe.sv - two-stage valid/ready ALU pipeline with sticky status
// Optional B-operand shifter built only when ALU_SHIFT_EN is defined.
module alu_pipe
   import alu_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] ain,
   input  logic [WIDTH-1:0] bin,
   input  logic [1:0]       alu_op,
   input  logic [1:0]       shift,
   input  logic             load_status,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out,
   output logic             z,
   output logic             n,
   output logic             v,
   output logic [2:0]       status
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_a_q, s1_a_d;
   logic [WIDTH-1:0] s1_b_q, s1_b_d;
   logic [1:0]       s1_op_q, s1_op_d;
   logic             s1_ld_q, s1_ld_d;

   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] s2_out_q, s2_out_d;
   logic             s2_z_q, s2_z_d;
   logic             s2_n_q, s2_n_d;
   logic             s2_v_q, s2_v_d;
   logic             s2_ld_q, s2_ld_d;

   logic [2:0]       status_q, status_d;

   logic [WIDTH-1:0] b_shifted;
   logic [WIDTH-1:0] core_res;
   logic             core_z, core_n, core_v;
   logic             s1_advance, accept, out_xfer;

`ifdef ALU_SHIFT_EN
   always_comb begin
      case (shift_e'(shift))
         SH_LSL1: b_shifted = {bin[WIDTH-2:0], 1'b0};
         SH_LSR1: b_shifted = {1'b0, bin[WIDTH-1:1]};
         SH_ASR1: b_shifted = {bin[WIDTH-1], bin[WIDTH-1:1]};
         default: b_shifted = bin;
      endcase
   end
`else
   logic unused_shift;
   assign unused_shift = ^shift;
   assign b_shifted    = bin;
`endif

   // S1 may move forward whenever S2 is empty or draining this cycle.
   assign s1_advance = s1_valid_q && (!s2_valid_q || out_ready);
   assign in_ready   = !s1_valid_q || s1_advance;
   assign accept     = in_valid && in_ready;
   assign out_xfer   = s2_valid_q && out_ready;

   alu_core #(.WIDTH(WIDTH)) u_core (
      .a      (s1_a_q),
      .b      (s1_b_q),
      .op     (s1_op_q),
      .result (core_res),
      .z      (core_z),
      .n      (core_n),
      .v      (core_v)
   );

   always_comb begin
      s1_valid_d = s1_valid_q;
      s1_a_d     = s1_a_q;
      s1_b_d     = s1_b_q;
      s1_op_d    = s1_op_q;
      s1_ld_d    = s1_ld_q;
      if (accept) begin
         s1_valid_d = 1'b1;
         s1_a_d     = ain;
         s1_b_d     = b_shifted;
         s1_op_d    = alu_op;
         s1_ld_d    = load_status;
      end else if (s1_advance) begin
         s1_valid_d = 1'b0;
      end
   end

   always_comb begin
      s2_valid_d = s2_valid_q;
      s2_out_d   = s2_out_q;
      s2_z_d     = s2_z_q;
      s2_n_d     = s2_n_q;
      s2_v_d     = s2_v_q;
      s2_ld_d    = s2_ld_q;
      if (s1_advance) begin
         s2_valid_d = 1'b1;
         s2_out_d   = core_res;
         s2_z_d     = core_z;
         s2_n_d     = core_n;
         s2_v_d     = core_v;
         s2_ld_d    = s1_ld_q;
      end else if (out_xfer) begin
         s2_valid_d = 1'b0;
      end
   end

   // Status only moves on a completed output transfer, never during a stall.
   always_comb begin
      status_d = status_q;
      if (out_xfer && s2_ld_q) begin
         status_d[ST_Z] = s2_z_q;
         status_d[ST_N] = s2_n_q;
         status_d[ST_V] = s2_v_q;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1_valid_q <= 1'b0;
         s1_a_q     <= '0;
         s1_b_q     <= '0;
         s1_op_q    <= '0;
         s1_ld_q    <= 1'b0;
         s2_valid_q <= 1'b0;
         s2_out_q   <= '0;
         s2_z_q     <= 1'b0;
         s2_n_q     <= 1'b0;
         s2_v_q     <= 1'b0;
         s2_ld_q    <= 1'b0;
         status_q   <= 3'b000;
      end else begin
         s1_valid_q <= s1_valid_d;
         s1_a_q     <= s1_a_d;
         s1_b_q     <= s1_b_d;
         s1_op_q    <= s1_op_d;
         s1_ld_q    <= s1_ld_d;
         s2_valid_q <= s2_valid_d;
         s2_out_q   <= s2_out_d;
         s2_z_q     <= s2_z_d;
         s2_n_q     <= s2_n_d;
         s2_v_q     <= s2_v_d;
         s2_ld_q    <= s2_ld_d;
         status_q   <= status_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign out       = s2_out_q;
   assign z         = s2_z_q;
   assign n         = s2_n_q;
   assign v         = s2_v_q;
   assign status    = status_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb/tb_alu_pipe.sv - directed and random checks of alu_pipe against a queue model
module tb_alu_pipe;
   import alu_pkg::*;

`ifdef ALU_SHIFT_EN
   localparam bit SHIFT_EN = 1'b1;
`else
   localparam bit SHIFT_EN = 1'b0;
`endif

   logic        clk;
   logic        reset_n;
   logic        in_valid, in_ready;
   logic [15:0] ain, bin;
   logic [1:0]  alu_op, shift;
   logic        load_status;
   logic        out_valid, out_ready;
   logic [15:0] out;
   logic        z, n, v;
   logic [2:0]  status;

   alu_pipe #(.WIDTH(16)) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ain         (ain),
      .bin         (bin),
      .alu_op      (alu_op),
      .shift       (shift),
      .load_status (load_status),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out         (out),
      .z           (z),
      .n           (n),
      .v           (v),
      .status      (status)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] res;
      logic        z, n, v, ld;
      int          cyc;
   } ent_t;

   ent_t        q[$];
   logic [2:0]  st_m;
   int          cyc;
   int          checks;
   int          failures;
   logic        m_ir;
   logic        s_ir, s_ov, s_z, s_n, s_v;
   logic [15:0] s_out;
   logic [2:0]  s_st;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic ent_t model(input logic [15:0] a, input logic [15:0] b,
                                  input logic [1:0] op, input logic [1:0] sh,
                                  input logic ld, input int c);
      ent_t e;
      int   av, bv, sa, sb, r;
      av = int'(a);
      bv = int'(b);
      if (SHIFT_EN) begin
         case (sh)
            2'b01:   bv = (bv * 2) % 65536;
            2'b10:   bv = bv / 2;
            2'b11:   bv = (bv >= 32768) ? bv / 2 + 32768 : bv / 2;
            default: bv = bv;
         endcase
      end
      sa  = (av >= 32768) ? av - 65536 : av;
      sb  = (bv >= 32768) ? bv - 65536 : bv;
      e.v = 1'b0;
      case (op)
         2'b00: begin
            r   = sa + sb;
            e.v = (r > 32767) || (r < -32768);
         end
         2'b01: begin
            r   = sa - sb;
            e.v = (r > 32767) || (r < -32768);
         end
         2'b10:   r = av & bv;
         default: r = 65535 - bv;
      endcase
      e.res = r[15:0];
      e.z   = (int'(e.res) == 0);
      e.n   = (int'(e.res) >= 32768);
      e.ld  = ld;
      e.cyc = c;
      return e;
   endfunction

   task automatic step(input logic iv, input logic [15:0] a, input logic [15:0] b,
                       input logic [1:0] op, input logic [1:0] sh, input logic ld,
                       input logic ordy);
      logic exp_ov;
      in_valid    = iv;
      ain         = a;
      bin         = b;
      alu_op      = op;
      shift       = sh;
      load_status = ld;
      out_ready   = ordy;
      #1;
      m_ir   = (q.size() < 2) || ordy;
      exp_ov = (q.size() > 0) && (cyc >= q[0].cyc + 2);
      s_ir   = in_ready;
      s_ov   = out_valid;
      s_out  = out;
      s_z    = z;
      s_n    = n;
      s_v    = v;
      s_st   = status;
      chk("in_ready", s_ir, m_ir);
      chk("out_valid", s_ov, exp_ov);
      if (exp_ov) begin
         chk("out", s_out, q[0].res);
         chk("flags", {s_v, s_n, s_z}, {q[0].v, q[0].n, q[0].z});
      end
      chk("status", s_st, st_m);
      @(posedge clk);
      if (exp_ov && ordy) begin
         if (q[0].ld) st_m = {q[0].v, q[0].n, q[0].z};
         void'(q.pop_front());
      end
      if (iv && m_ir) q.push_back(model(a, b, op, sh, ld, cyc));
      cyc++;
      @(negedge clk);
   endtask

   task automatic idle();
      step(1'b0, 16'h0, 16'h0, ALU_ADD, SH_NONE, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      in_valid = 1'b0;
      reset_n  = 1'b0;
      #1;
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out", out, 16'h0);
      chk("rst_flags", {v, n, z}, 3'b000);
      chk("rst_status", status, 3'b000);
      q.delete();
      st_m = 3'b000;
      @(posedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      chk("rst_in_ready", in_ready, 1'b1);
   endtask

   function automatic logic [15:0] pick();
      case ($urandom_range(0, 5))
         0:       return 16'h0000;
         1:       return 16'h7FFF;
         2:       return 16'h8000;
         3:       return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   initial begin
      logic        r_iv, r_ld, r_ordy, pending;
      logic [15:0] r_a, r_b;
      logic [1:0]  r_op, r_sh;
      logic [15:0] exp_asr;

      checks = 0; failures = 0; cyc = 0; st_m = 3'b000;
      reset_n = 1'b0; in_valid = 1'b0; ain = '0; bin = '0;
      alu_op = '0; shift = '0; load_status = 1'b0; out_ready = 1'b0;
      @(negedge clk);
      do_reset();

      // ADD latency
      step(1'b1, 16'd5, 16'd7, ALU_ADD, SH_NONE, 1'b0, 1'b1);
      idle();
      chk("add_early_ov", s_ov, 1'b0);
      idle();
      chk("add_ov", s_ov, 1'b1);
      chk("add_out", s_out, 16'd12);
      chk("add_flags", {s_v, s_n, s_z}, 3'b000);

      // SUB to zero with status load
      step(1'b1, 16'd45, 16'd45, ALU_SUB, SH_NONE, 1'b1, 1'b1);
      idle();
      idle();
      chk("sub_out", s_out, 16'd0);
      chk("sub_z", s_z, 1'b1);
      idle();
      chk("sub_status", s_st, 3'b001);

      // signed overflow
      step(1'b1, 16'h7FFF, 16'hFFFF, ALU_SUB, SH_NONE, 1'b0, 1'b1);
      idle();
      idle();
      chk("ovf_out", s_out, 16'h8000);
      chk("ovf_nv", {s_v, s_n}, 2'b11);

      // MVN followed back-to-back by ASR1 ADD
      exp_asr = SHIFT_EN ? 16'hC000 : 16'h8001;
      step(1'b1, 16'h1234, 16'h00FF, ALU_MVN, SH_NONE, 1'b0, 1'b1);
      step(1'b1, 16'h0000, 16'h8001, ALU_ADD, SH_ASR1, 1'b0, 1'b1);
      idle();
      chk("mvn_out", s_out, 16'hFF00);
      chk("mvn_n", s_n, 1'b1);
      idle();
      chk("asr_out", s_out, exp_asr);

      // backpressure: five stalled cycles, then drain
      step(1'b1, 16'd1, 16'd1, ALU_ADD, SH_NONE, 1'b0, 1'b0);
      step(1'b1, 16'd2, 16'd2, ALU_ADD, SH_NONE, 1'b1, 1'b0);
      for (int i = 0; i < 3; i++) begin
         step(1'b1, 16'd3, 16'd3, ALU_ADD, SH_NONE, 1'b0, 1'b0);
         chk("bp_in_ready_low", s_ir, 1'b0);
         chk("bp_hold_out", s_out, 16'd2);
         chk("bp_hold_status", s_st, 3'b001);
      end
      step(1'b1, 16'd3, 16'd3, ALU_ADD, SH_NONE, 1'b0, 1'b1);
      chk("bp_in_ready_rise", s_ir, 1'b1);
      chk("bp_out1", s_out, 16'd2);
      step(1'b1, 16'd4, 16'd4, ALU_ADD, SH_NONE, 1'b1, 1'b1);
      chk("bp_out2", s_out, 16'd4);
      chk("bp_status_no_ld", s_st, 3'b001);
      idle();
      chk("bp_out3", s_out, 16'd6);
      chk("bp_status_ld", s_st, 3'b000);
      idle();
      chk("bp_out4", s_out, 16'd8);
      idle();
      chk("bp_drained", s_ov, 1'b0);

      // negative result loaded into status, then reset with two in flight
      step(1'b1, 16'd0, 16'd1, ALU_SUB, SH_NONE, 1'b1, 1'b1);
      idle();
      idle();
      idle();
      chk("neg_status", s_st, 3'b010);
      step(1'b1, 16'd9, 16'd9, ALU_ADD, SH_NONE, 1'b1, 1'b0);
      step(1'b1, 16'd10, 16'd10, ALU_ADD, SH_NONE, 1'b1, 1'b0);
      in_valid  = 1'b0;
      out_ready = 1'b0;
      #1;
      chk("pre_rst_ov", out_valid, 1'b1);
      do_reset();
      for (int i = 0; i < 4; i++) idle();

      // randomized traffic with random backpressure
      pending = 1'b0;
      r_iv = 1'b0; r_a = '0; r_b = '0; r_op = '0; r_sh = '0; r_ld = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!pending) begin
            r_iv = ($urandom_range(0, 9) < 7);
            r_a  = pick();
            r_b  = pick();
            r_op = 2'($urandom_range(0, 3));
            r_sh = 2'($urandom_range(0, 3));
            r_ld = 1'($urandom_range(0, 1));
         end
         r_ordy = ($urandom_range(0, 9) < 6);
         step(r_iv, r_a, r_b, r_op, r_sh, r_ld, r_ordy);
         pending = r_iv && !m_ir;
      end
      for (int i = 0; i < 4; i++) idle();
      chk("final_drained", out_valid, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
